// File: rtl/arkhe_handover_scheduler.sv
// Handover scheduler: round-robin grant of a source, scale its state by its fidelity, present result.
// Latency: req sampled at edge k -> ack during cycle k+1 -> out_valid from cycle k+2 (issue every >= 3 cycles).
// Backpressure: result held stable while out_valid && !out_ready; new requests ignored until back in IDLE.
// Optional build macro ARKHE_HANDOVER_SATURATE_EN clamps the scaled result to the signed WIDTH range.
module arkhe_handover_scheduler #(
    parameter int                NUM_NODES        = 4,
    parameter int                WIDTH            = 32,
    parameter int                FID_W            = 18,
    parameter logic [FID_W-1:0]  DEFAULT_FIDELITY = 18'h0F000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_NODES-1:0]           req,
    input  logic [NUM_NODES*WIDTH-1:0]     src_state,
    input  logic [NUM_NODES*8-1:0]         src_tgt,
    output logic [NUM_NODES-1:0]           ack,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_NODES)-1:0]   cfg_addr,
    input  logic [FID_W-1:0]               cfg_fidelity,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [3:0]                     out_src,
    output logic [7:0]                     out_tgt,
    output logic [WIDTH-1:0]               out_coupling,
    output logic                           busy
);

    localparam int IDXW = $clog2(NUM_NODES);
    localparam int PW   = WIDTH + FID_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        last_grant_q, last_grant_d;
    logic [NUM_NODES-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]       cap_state_q, cap_state_d;
    logic [FID_W-1:0]       cap_fid_q, cap_fid_d;
    logic                   out_valid_q, out_valid_d;
    logic [3:0]             out_src_q, out_src_d;
    logic [7:0]             out_tgt_q, out_tgt_d;
    logic [WIDTH-1:0]       out_coupling_q, out_coupling_d;
    logic [FID_W-1:0]       fid_q [NUM_NODES];

    logic [WIDTH-1:0]       state_arr [NUM_NODES];
    logic [7:0]             tgt_arr   [NUM_NODES];

    logic                   found;
    logic [IDXW-1:0]        grant_idx;
    logic [IDXW-1:0]        cand_idx;
    logic                   cfg_in_range;

    logic signed [PW-1:0]    prod;
    logic signed [PW-17:0]   hi;
    logic [WIDTH-1:0]        coupling;
    logic                    unused_prod_lo;

    // Unflatten the per-source buses so a granted index selects whole slices.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_unpack
        assign state_arr[g] = src_state[g*WIDTH +: WIDTH];
        assign tgt_arr[g]   = src_tgt[g*8 +: 8];
    end

    assign cfg_in_range = ({1'b0, cfg_addr} < (IDXW+1)'(NUM_NODES));

    // Round-robin search starting one past the previous grant.
    always_comb begin
        found     = 1'b0;
        grant_idx = last_grant_q;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_NODES; i++) begin
            cand_idx = IDXW'((int'(last_grant_q) + i) % NUM_NODES);
            if (!found && req[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Full-precision signed product; fidelity is unsigned so it gets a zero sign bit.
    always_comb begin
        prod = PW'($signed(cap_state_q)) * PW'($signed({1'b0, cap_fid_q}));
        hi   = $signed(prod[PW-1:16]);
    end

    assign unused_prod_lo = ^prod[15:0];

`ifdef ARKHE_HANDOVER_SATURATE_EN
    localparam logic signed [PW-17:0] SMAX = {{(PW-16-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-17:0] SMIN = {{(PW-16-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    // Clamp the shifted product into the signed WIDTH range.
    always_comb begin
        coupling = hi[WIDTH-1:0];
        if (hi > SMAX) begin
            coupling = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (hi < SMIN) begin
            coupling = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    logic unused_prod_hi;

    // Plain wrap: keep the low WIDTH bits of the shifted product.
    always_comb begin
        coupling = hi[WIDTH-1:0];
    end

    assign unused_prod_hi = ^hi[PW-17:WIDTH];
`endif

    // Next-state and registered-output decode for the IDLE/CALC/OUT sequence.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        ack_d          = '0;
        cap_state_d    = cap_state_q;
        cap_fid_d      = cap_fid_q;
        out_valid_d    = out_valid_q;
        out_src_d      = out_src_q;
        out_tgt_d      = out_tgt_q;
        out_coupling_d = out_coupling_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d      = S_CALC;
                    last_grant_d = grant_idx;
                    ack_d        = NUM_NODES'(1) << grant_idx;
                    cap_state_d  = state_arr[grant_idx];
                    cap_fid_d    = fid_q[grant_idx];
                    out_src_d    = 4'(grant_idx);
                    out_tgt_d    = tgt_arr[grant_idx];
                end
            end
            S_CALC: begin
                out_coupling_d = coupling;
                out_valid_d    = 1'b1;
                state_d        = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Grant pointer, capture and result registers; reset discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q   <= IDXW'(NUM_NODES - 1);
            ack_q          <= '0;
            cap_state_q    <= '0;
            cap_fid_q      <= '0;
            out_valid_q    <= 1'b0;
            out_src_q      <= '0;
            out_tgt_q      <= '0;
            out_coupling_q <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            ack_q          <= ack_d;
            cap_state_q    <= cap_state_d;
            cap_fid_q      <= cap_fid_d;
            out_valid_q    <= out_valid_d;
            out_src_q      <= out_src_d;
            out_tgt_q      <= out_tgt_d;
            out_coupling_q <= out_coupling_d;
        end
    end

    // Fidelity table; writable in any state, capture reads the pre-write value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NODES; i++) fid_q[i] <= DEFAULT_FIDELITY;
        end else if (cfg_we && cfg_in_range) begin
            fid_q[cfg_addr] <= cfg_fidelity;
        end
    end

    assign ack          = ack_q;
    assign out_valid    = out_valid_q;
    assign out_src      = out_src_q;
    assign out_tgt      = out_tgt_q;
    assign out_coupling = out_coupling_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_arkhe_handover_scheduler.sv
// Directed bench for arkhe_handover_scheduler with an expected-result queue.
module tb_arkhe_handover_scheduler;

    localparam int N = 4;
    localparam int W = 32;
    localparam int F = 18;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] src_state = '0;
    logic [N*8-1:0] src_tgt = '0;
    logic [N-1:0]   ack;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_addr = '0;
    logic [F-1:0]   cfg_fidelity = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [3:0]     out_src;
    logic [7:0]     out_tgt;
    logic [W-1:0]   out_coupling;
    logic           busy;

    arkhe_handover_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .src_state    (src_state),
        .src_tgt      (src_tgt),
        .ack          (ack),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_fidelity (cfg_fidelity),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .out_tgt      (out_tgt),
        .out_coupling (out_coupling),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  src;
        logic [7:0]  tgt;
        logic [31:0] cpl;
    } exp_t;

    exp_t         sb[$];
    logic [F-1:0] fid_m [N];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] s, input logic [F-1:0] f);
        longint p;
        p = longint'($signed(s)) * longint'({46'b0, f});
        p = p >>> 16;
`ifdef ARKHE_HANDOVER_SATURATE_EN
        if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (p < -64'sd2147483648) return 32'h8000_0000;
`endif
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_src(input int i, input logic [31:0] st, input logic [7:0] tg);
        src_state[i*W +: W] = st;
        src_tgt[i*8 +: 8]   = tg;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.src = 4'(i);
        e.tgt = src_tgt[i*8 +: 8];
        e.cpl = model(src_state[i*W +: W], fid_m[i]);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_tgt", 64'(out_tgt), 64'd0);
        chk("rst_cpl", 64'(out_coupling), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) fid_m[i] = 18'h0F000;
    endtask

    task automatic wait_ack(output logic [N-1:0] a);
        a = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack != '0) begin
                a = ack;
                break;
            end
        end
        chk("ack_seen", 64'(a != '0), 64'd1);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_src"}, 64'(out_src), 64'(e.src));
            chk({tag, "_tgt"}, 64'(out_tgt), 64'(e.tgt));
            chk({tag, "_cpl"}, 64'(out_coupling), 64'(e.cpl));
        end
    endtask

    initial begin
        logic [N-1:0] a;
        int           last_cyc;

        // Basic transaction with exact timing.
        do_reset();
        set_src(0, 32'h0001_0000, 8'd5);
        out_ready = 1'b1;
        req = 4'b0001;
        push_exp(0);
        tick();
        chk("t1_ack", 64'(ack), 64'b0001);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_early", 64'(out_valid), 64'd0);
        req = '0;
        tick();
        chk("t1_cpl_lit", 64'(out_coupling), 64'h0000_F000);
        check_out("t1");
        tick();
        chk("t1_valid_clr", 64'(out_valid), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Round-robin order with all sources requesting.
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 32'((i + 1) << 16), 8'(8'h10 + i));
        req = 4'b1111;
        last_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack(a);
            chk("t2_ack", 64'(a), 64'(1 << (g % N)));
            if (g > 0) chk("t2_gap", 64'(cyc - last_cyc), 64'd3);
            last_cyc = cyc;
            push_exp(g % N);
            tick();
            check_out("t2");
            tick();
        end
        req = '0;

        // Downstream stall for 10 cycles.
        req = 4'b1111;
        out_ready = 1'b0;
        wait_ack(a);
        chk("t3_ack", 64'(a), 64'b0010);
        push_exp(1);
        tick();
        for (int s = 0; s < 10; s++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_src", 64'(out_src), 64'(sb[0].src));
            chk("t3_hold_cpl", 64'(out_coupling), 64'(sb[0].cpl));
            chk("t3_no_ack", 64'(ack), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        check_out("t3");
        tick();
        req = '0;
        chk("t3_idle", 64'(busy), 64'd0);
        chk("t3_valid_clr", 64'(out_valid), 64'd0);

        // Fidelity 2.0 overflow: wrap or clamp depending on build.
        cfg_we = 1'b1;
        cfg_addr = 2'd2;
        cfg_fidelity = 18'h20000;
        tick();
        cfg_we = 1'b0;
        fid_m[2] = 18'h20000;
        set_src(2, 32'h7FFF_0000, 8'hA2);
        req = 4'b0100;
        wait_ack(a);
        chk("t4_ack", 64'(a), 64'b0100);
        req = '0;
        push_exp(2);
        tick();
`ifdef ARKHE_HANDOVER_SATURATE_EN
        chk("t4_cpl_lit", 64'(out_coupling), 64'h7FFF_FFFF);
`else
        chk("t4_cpl_lit", 64'(out_coupling), 64'hFFFE_0000);
`endif
        check_out("t4");
        tick();
        set_src(2, 32'h8000_0000, 8'hA3);
        req = 4'b0100;
        wait_ack(a);
        chk("t4n_ack", 64'(a), 64'b0100);
        req = '0;
        push_exp(2);
        tick();
        check_out("t4n");
        tick();

        // Fidelity write in the capture cycle of the same source.
        set_src(1, 32'h0001_0000, 8'h51);
        req = 4'b0010;
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_fidelity = 18'h08000;
        push_exp(1);
        tick();
        chk("t5_ack", 64'(ack), 64'b0010);
        cfg_we = 1'b0;
        fid_m[1] = 18'h08000;
        req = '0;
        tick();
        check_out("t5_old_fid");
        tick();
        req = 4'b0010;
        wait_ack(a);
        chk("t5b_ack", 64'(a), 64'b0010);
        req = '0;
        push_exp(1);
        tick();
        check_out("t5_new_fid");
        tick();

        // Reset while in CALC discards the transaction.
        set_src(0, 32'h0001_0000, 8'd5);
        req = 4'b0001;
        wait_ack(a);
        chk("t6_ack", 64'(a), 64'b0001);
        req = '0;
        rst_n = 1'b0;
        tick();
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) fid_m[i] = 18'h0F000;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t6_post_valid", 64'(out_valid), 64'd0);
            chk("t6_post_ack", 64'(ack), 64'd0);
        end
        req = 4'b1111;
        wait_ack(a);
        chk("t6_first_grant", 64'(a), 64'b0001);
        push_exp(0);
        tick();
        check_out("t6a");
        tick();
        wait_ack(a);
        chk("t6_second_grant", 64'(a), 64'b0010);
        push_exp(1);
        tick();
        check_out("t6b_fid_reset");
        tick();
        req = '0;

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arkhe_handover_scheduler.md
ARKHE_HANDOVER_SCHEDULER -- requirements
Module: arkhe_handover_scheduler

Interface
REQ-001 SHALL have parameter NUM_NODES, default 4: number of requesting source nodes (2..16).
REQ-002 SHALL have parameter WIDTH, default 32: state and coupling width, signed Q16.16.
REQ-003 SHALL have parameter FID_W, default 18: fidelity width, unsigned Q2.16.
REQ-004 SHALL have parameter DEFAULT_FIDELITY, default 18'h0F000: per-source fidelity after reset (0.9375).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port req, input, NUM_NODES: per-source handover request, level.
REQ-008 SHALL have port src_state, input, NUM_NODES*WIDTH: flattened source states; slice i belongs to source i.
REQ-009 SHALL have port src_tgt, input, NUM_NODES*8: flattened target IDs.
REQ-010 SHALL have port ack, output, NUM_NODES: one-cycle capture pulse per source.
REQ-011 SHALL have port cfg_we, input, 1: fidelity write strobe.
REQ-012 SHALL have port cfg_addr, input, clog2(NUM_NODES): fidelity register index.
REQ-013 SHALL have port cfg_fidelity, input, FID_W: fidelity write data.
REQ-014 SHALL have port out_valid, output, 1: coupling result valid.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-016 SHALL have port out_src, output, 4: granted source index.
REQ-017 SHALL have port out_tgt, output, 8: target ID of the result.
REQ-018 SHALL have port out_coupling, output, WIDTH: scaled coupling, signed Q16.16.
REQ-019 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-020 SHALL implement a three-state FSM: IDLE, CALC, OUT.
REQ-021 In IDLE, when req is nonzero, SHALL grant one source, capture its state, target and fidelity, pulse ack[grant] for exactly the next cycle, and enter CALC.
REQ-022 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_NODES; last_grant updates on each grant.
REQ-023 In CALC, SHALL register out_coupling = (state * fidelity) >>> 16, with full-precision signed product and fidelity zero-extended; SHALL set out_valid and enter OUT.
REQ-024 Timing: req sampled at edge k gives ack high during cycle k+1 and out_valid high from cycle k+2.
REQ-025 In OUT, SHALL hold out_valid, out_src, out_tgt and out_coupling stable until out_valid && out_ready; the handshake edge clears out_valid and returns to IDLE.
REQ-026 Minimum issue interval SHALL be 3 cycles; req SHALL be ignored outside IDLE.
REQ-027 A source dropping req before its grant SHALL NOT be captured and SHALL receive no ack.
REQ-028 cfg_we SHALL write fidelity[cfg_addr] at any state; a write in the capture cycle of the same source SHALL leave the captured value as the old fidelity.
REQ-029 cfg_addr >= NUM_NODES SHALL be ignored.
REQ-030 Without saturation, the result SHALL be the low WIDTH bits of the shifted product (wrap).

Reset
REQ-031 While rst_n is sampled low: state SHALL be IDLE, with ack, out_valid, out_src, out_tgt, out_coupling and busy all 0.
REQ-032 While rst_n is sampled low: last_grant SHALL be NUM_NODES-1, so source 0 has first priority.
REQ-033 While rst_n is sampled low: all fidelity registers SHALL equal DEFAULT_FIDELITY.
REQ-034 Reset asserted mid-transaction SHALL discard it, producing no out_valid and no ack afterwards.

Configuration
REQ-035 When ARKHE_HANDOVER_SATURATE_EN is defined, results above the max or below the min signed WIDTH value SHALL clamp to 0x7FFF_FFFF or 0x8000_0000; when undefined, REQ-030 wrap applies and no clamp logic exists.

Verification
REQ-036 Reset, then req=0001, src_state[0]=0x0001_0000, tgt=5, out_ready=1 -> ack=0001 at k+1; out_valid at k+2 with out_coupling=0x0000_F000, out_src=0, out_tgt=5.
REQ-037 req=1111 held with out_ready=1 -> grant order 0,1,2,3,0, each issue 3 cycles apart.
REQ-038 out_ready=0 for 10 cycles during OUT -> out_valid and data stable for 10 cycles, no new ack; out_ready=1 -> IDLE on the next edge.
REQ-039 cfg write fidelity[2]=0x20000, then src_state=0x7FFF_0000 -> out_coupling=0x7FFF_FFFF with the macro, 0xFFFE_0000 without.
REQ-040 rst_n low for 1 cycle while in CALC -> out_valid stays 0, fidelities return to 0x0F000, next grant goes to source 0.
